// File: rtl/pwm_mixer_pkg.sv
// Shared limits and decode direction type for the pwm_mixer slice.
package pwm_mixer_pkg;

  localparam int unsigned MAX_CHANNELS = 16;
  localparam int unsigned MAX_WIDTH    = 16;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN
  } dir_t;

endpackage

// File: rtl/pwm_mixer_encoder_channel.sv
// One encoder channel: 2-flop synchroniser, optional debounce filter
// (PWM_MIXER_DEBOUNCE_EN), x1 quadrature decode and a WIDTH-bit level register.
module encoder_channel
  import pwm_mixer_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned STEP            = 1,
  parameter int unsigned WRAP            = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  output logic [WIDTH-1:0] level
);

  if (STEP < 1 || STEP > (1 << WIDTH) - 1) begin : g_bad_step
    $error("encoder_channel: STEP out of range");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_db
    $error("encoder_channel: DEBOUNCE_CYCLES out of range");
  end

  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

  logic [1:0]       a_sync_q, b_sync_q;
  logic [1:0]       raw;
  logic             fa, fb;
  logic             fa_prev_q;
  dir_t             dir_q, dir_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH:0]   sum, diff;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_sync_q <= {a_sync_q[0], enc_a};
      b_sync_q <= {b_sync_q[0], enc_b};
    end
  end

  assign raw = {b_sync_q[1], a_sync_q[1]};

`ifdef PWM_MIXER_DEBOUNCE_EN
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      filt_q, filt_d;
  logic [1:0][7:0] dbc_q, dbc_d;

  // Filter follows the input only after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    filt_d = filt_q;
    dbc_d  = dbc_q;
    for (int unsigned p = 0; p < 2; p++) begin
      if (raw[p] != filt_q[p]) begin
        if (dbc_q[p] == DB_LAST) begin
          filt_d[p] = raw[p];
          dbc_d[p]  = '0;
        end else begin
          dbc_d[p] = dbc_q[p] + 8'd1;
        end
      end else begin
        dbc_d[p] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= '0;
      dbc_q  <= '0;
    end else begin
      filt_q <= filt_d;
      dbc_q  <= dbc_d;
    end
  end

  assign {fb, fa} = filt_q;
`else
  assign {fb, fa} = raw;
`endif

  always_comb begin
    dir_d = DIR_NONE;
    if (fa && !fa_prev_q) begin
      dir_d = fb ? DIR_DOWN : DIR_UP;
    end
  end

  // WIDTH+1-bit arithmetic: bit WIDTH flags overflow (up) or borrow (down).
  always_comb begin
    sum     = {1'b0, level_q} + STEP_X;
    diff    = {1'b0, level_q} - STEP_X;
    level_d = level_q;
    unique case (dir_q)
      DIR_UP:   level_d = (WRAP == 0 && sum[WIDTH])  ? '1 : sum[WIDTH-1:0];
      DIR_DOWN: level_d = (WRAP == 0 && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
      default:  level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fa_prev_q <= 1'b0;
      dir_q     <= DIR_NONE;
      level_q   <= '0;
    end else begin
      fa_prev_q <= fa;
      dir_q     <= dir_d;
      level_q   <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/pwm_mixer.sv
// N-channel encoder-to-PWM mixer with shared period counter and double-buffered
// duty. Optional input debounce via macro PWM_MIXER_DEBOUNCE_EN.
module pwm_mixer
  import pwm_mixer_pkg::*;
#(
  parameter int unsigned CHANNELS        = 3,
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned STEP            = 1,
  parameter int unsigned WRAP            = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enc_a,
  input  logic [CHANNELS-1:0]       enc_b,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      sync,
  output logic [CHANNELS*WIDTH-1:0] level
);

  if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS || WIDTH < 4 || WIDTH > MAX_WIDTH) begin : g_bad_cfg
    $error("pwm_mixer: CHANNELS or WIDTH out of range");
  end

  logic [WIDTH-1:0]                cnt_q, cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  duty_q, duty_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  lvl;
  logic [CHANNELS-1:0]             pwm_q, pwm_d;
  logic                            sync_q, sync_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    encoder_channel #(
      .WIDTH          (WIDTH),
      .STEP           (STEP),
      .WRAP           (WRAP),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enc (
      .clk  (clk),
      .reset(reset),
      .enc_a(enc_a[i]),
      .enc_b(enc_b[i]),
      .level(lvl[i])
    );
  end

  // Duty shadows load on the last count so new levels start at cnt = 0.
  always_comb begin
    cnt_d  = cnt_q + WIDTH'(1);
    duty_d = duty_q;
    if (cnt_q == '1) begin
      duty_d = lvl;
    end
    sync_d = (cnt_q == '0);
    pwm_d  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = (cnt_q < duty_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= '0;
      sync_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
      sync_q <= sync_d;
    end
  end

  assign pwm_out = pwm_q;
  assign sync    = sync_q;
  assign level   = lvl;

endmodule

// File: tb/tb_pwm_mixer.sv
// Scoreboard bench for pwm_mixer: main 3-channel instance plus single-channel
// instances for saturation (STEP=16), wrap (WRAP=1) and double-buffer (STEP=10).
module tb_pwm_mixer;

  localparam int DB = 4;
`ifdef PWM_MIXER_DEBOUNCE_EN
  localparam int LAT = 3 + DB;
  localparam int H   = DB + 1;
`else
  localparam int LAT = 3;
  localparam int H   = 2;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]  a_m = '0, b_m = '0, pwm_m;
  logic        sync_m;
  logic [23:0] lvl_m;
  logic        a_s = 1'b0, b_s = 1'b0, pwm_s, sync_s;
  logic [7:0]  lvl_s;
  logic        a_w = 1'b0, b_w = 1'b0, pwm_w, sync_w;
  logic [7:0]  lvl_w;
  logic        a_d = 1'b0, b_d = 1'b0, pwm_d, sync_d;
  logic [7:0]  lvl_d;

  pwm_mixer #(.CHANNELS(3), .WIDTH(8), .STEP(1), .WRAP(0), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .enc_a(a_m), .enc_b(b_m),
    .pwm_out(pwm_m), .sync(sync_m), .level(lvl_m));

  pwm_mixer #(.CHANNELS(1), .WIDTH(8), .STEP(16), .WRAP(0), .DEBOUNCE_CYCLES(DB)) dut_s16 (
    .clk(clk), .reset(reset), .enc_a(a_s), .enc_b(b_s),
    .pwm_out(pwm_s), .sync(sync_s), .level(lvl_s));

  pwm_mixer #(.CHANNELS(1), .WIDTH(8), .STEP(1), .WRAP(1), .DEBOUNCE_CYCLES(DB)) dut_wrap (
    .clk(clk), .reset(reset), .enc_a(a_w), .enc_b(b_w),
    .pwm_out(pwm_w), .sync(sync_w), .level(lvl_w));

  pwm_mixer #(.CHANNELS(1), .WIDTH(8), .STEP(10), .WRAP(0), .DEBOUNCE_CYCLES(DB)) dut_db (
    .clk(clk), .reset(reset), .enc_a(a_d), .enc_b(b_d),
    .pwm_out(pwm_d), .sync(sync_d), .level(lvl_d));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int next_lvl(input int l, input bit up, input int step, input bit wrap);
    int v;
    v = up ? l + step : l - step;
    if (wrap) return (v + 512) % 256;
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  typedef struct {
    int ch;
    int val;
    int due;
  } exp_t;

  exp_t sb[$];
  int   mdl[3];
  int   mdl_s = 0, mdl_w = 0, mdl_d = 0;
  int   hi_run[5];
  int   hi_last[5];

  // Monitor: pops scoreboard on every main-instance level change, tallies PWM highs per period.
  initial begin : mon
    int prev_lvl[3];
    int cur, idx;
    logic [4:0] pv;
    for (int c = 0; c < 3; c++) prev_lvl[c] = 0;
    for (int j = 0; j < 5; j++) begin
      hi_run[j] = 0;
      hi_last[j] = 0;
    end
    forever begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        cur = int'(lvl_m[c*8 +: 8]);
        if (cur != prev_lvl[c]) begin
          idx = -1;
          for (int j = 0; j < sb.size(); j++) if (idx < 0 && sb[j].ch == c) idx = j;
          if (idx < 0) begin
            check("sb_unexpected", cur, prev_lvl[c]);
          end else begin
            check("sb_level", cur, sb[idx].val);
            check("sb_latency", cyc, sb[idx].due);
            sb.delete(idx);
          end
          prev_lvl[c] = cur;
        end
      end
      pv = {pwm_d, pwm_s, pwm_m};
      for (int j = 0; j < 5; j++) begin
        if (sync_m) begin
          hi_last[j] = hi_run[j];
          hi_run[j]  = int'(pv[j]);
        end else begin
          hi_run[j] += int'(pv[j]);
        end
      end
    end
  end

  task automatic set_ab(input int tgt, input bit is_a, input logic [2:0] v);
    case (tgt)
      0: if (is_a) a_m = v; else b_m = v;
      1: if (is_a) a_s = v[0]; else b_s = v[0];
      2: if (is_a) a_w = v[0]; else b_w = v[0];
      default: if (is_a) a_d = v[0]; else b_d = v[0];
    endcase
  endtask

  // One detent: B set first, A high for H cycles, A low for H cycles, B cleared.
  task automatic drive(input int tgt, input logic [2:0] up, input logic [2:0] dn);
    logic [2:0] m;
    m = up | dn;
    @(negedge clk);
    set_ab(tgt, 1'b0, dn);
    @(negedge clk);
    set_ab(tgt, 1'b1, m);
    case (tgt)
      0: for (int c = 0; c < 3; c++) begin
           if (m[c]) begin
             mdl[c] = next_lvl(mdl[c], up[c], 1, 1'b0);
             sb.push_back(exp_t'{c, mdl[c], cyc + 1 + LAT});
           end
         end
      1: mdl_s = next_lvl(mdl_s, up[0], 16, 1'b0);
      2: mdl_w = next_lvl(mdl_w, up[0], 1, 1'b1);
      default: mdl_d = next_lvl(mdl_d, up[0], 10, 1'b0);
    endcase
    repeat (H) @(negedge clk);
    set_ab(tgt, 1'b1, 3'b000);
    repeat (H) @(negedge clk);
    set_ab(tgt, 1'b0, 3'b000);
  endtask

  task automatic wait_sync(output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      #1;
      n++;
      if (sync_m) found = 1'b1;
    end
    if (!found) check("sync_timeout", 32'd0, 32'd1);
  endtask

  initial begin : stim
    int n;
    for (int c = 0; c < 3; c++) mdl[c] = 0;

    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_level_m", 32'(lvl_m), 32'd0);
    check("rst_pwm_m", 32'(pwm_m), 32'd0);
    check("rst_sync_m", 32'(sync_m), 32'd0);
    check("rst_misc", 32'({lvl_s, lvl_w, lvl_d}), 32'd0);
    check("rst_misc_out", 32'({pwm_s, pwm_w, pwm_d, sync_s, sync_w, sync_d}), 32'd0);
    reset = 1'b0;

    @(negedge clk);
    check("sync_first", 32'({sync_m, sync_s, sync_w, sync_d}), 32'hF);
    check("pwm_first", 32'(pwm_m), 32'd0);
    for (int p = 0; p < 3; p++) begin
      wait_sync(n);
      check("sync_period", n, 256);
    end
    check("idle_pwm0", hi_last[0], 0);
    check("idle_level", 32'(lvl_m), 32'd0);

    // Increment: ten detents on ch0.
    repeat (10) drive(0, 3'b001, 3'b000);
    check("inc_level0", 32'(lvl_m[7:0]), 32'd10);
    wait_sync(n);
    wait_sync(n);
    check("inc_pwm0_hi", hi_last[0], 10);
    check("inc_pwm1_hi", hi_last[1], 0);
    check("inc_pwm2_hi", hi_last[2], 0);
    check("inc_level12", 32'(lvl_m[23:8]), 32'd0);

    // Double buffer: 10 -> 200 mid-period on the STEP=10 instance.
    drive(3, 3'b001, 3'b000);
    check("dbuf_lvl10", 32'(lvl_d), mdl_d);
    wait_sync(n);
    wait_sync(n);
    check("dbuf_pre", hi_last[4], 10);
    wait_sync(n);
    repeat (19) drive(3, 3'b001, 3'b000);
    check("dbuf_level", 32'(lvl_d), 32'd200);
    wait_sync(n);
    check("dbuf_hold", hi_last[4], 10);
    wait_sync(n);
    check("dbuf_new", hi_last[4], 200);

    // Saturation: decrement at 0, then ramp past the top with STEP=16.
    drive(1, 3'b000, 3'b001);
    check("sat_low", 32'(lvl_s), 32'd0);
    for (int i = 0; i < 20; i++) begin
      drive(1, 3'b001, 3'b000);
      check("sat_ramp", 32'(lvl_s), mdl_s);
    end
    check("sat_top", 32'(lvl_s), 32'd255);
    wait_sync(n);
    wait_sync(n);
    check("sat_pwm_hi", hi_last[3], 255);

    // Wrap instance: 0 - 1 -> 255, then 255 + 1 -> 0.
    drive(2, 3'b000, 3'b001);
    check("wrap_dn", 32'(lvl_w), 32'd255);
    drive(2, 3'b001, 3'b000);
    check("wrap_up", 32'(lvl_w), 32'd0);
    check("wrap_pwm", 32'(pwm_w), 32'd0);

`ifdef PWM_MIXER_DEBOUNCE_EN
    @(negedge clk);
    a_m[0] = 1'b1;
    repeat (DB - 1) @(negedge clk);
    a_m[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("db_glitch", 32'(lvl_m[7:0]), mdl[0]);
    a_m[0] = 1'b1;
    mdl[0] = next_lvl(mdl[0], 1'b1, 1, 1'b0);
    sb.push_back(exp_t'{0, mdl[0], cyc + 1 + LAT});
    repeat (DB) @(negedge clk);
    a_m[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("db_pass", 32'(lvl_m[7:0]), mdl[0]);
`endif

    // Simultaneous: ch1/ch2 to 50, then ch1 up and ch2 down in one detent.
    repeat (50) drive(0, 3'b110, 3'b000);
    drive(0, 3'b010, 3'b100);
    check("simul_ch1", 32'(lvl_m[15:8]), 32'd51);
    check("simul_ch2", 32'(lvl_m[23:16]), 32'd49);

    repeat (10) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
